dmem_access_unit: RTL and testbench

Multi-cycle load/store unit forming the memory stage between execute and writeback in the hart. It accepts one load or store per handshake from execute and checks alignment and width legality. It drives a latency-tolerant data memory port with a word-aligned address, byte mask and lane-shifted write data. It returns the sign- or zero-extended load result, or a trap flag, to writeback as a one-cycle response pulse.

---
 rtl/dmem_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Memory stage load/store unit: legality check, lane alignment towards the data
// memory port, and extension of load data into a one-cycle writeback response.
module dmem_access_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [4:0]  i_req_rd,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic [4:0]  o_rsp_rd,
    output logic        o_rsp_trap
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic        wen_q, wen_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_trap_q, rsp_trap_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;

    logic        req_fire;
    logic        req_trap;
    logic [3:0]  req_mask;
    logic        mem_done;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    assign req_fire = i_req_valid && (state_q == S_IDLE);
    assign mem_done = ((state_q == S_REQ) && i_mem_ready && i_mem_valid)
                   || ((state_q == S_WAIT) && i_mem_valid);

    // NOTE: every variable an always_comb writes gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        req_trap = 1'b0;
        case (i_req_funct3)
            3'b000:  req_trap = 1'b0;
            3'b001:  req_trap = i_req_addr[0];
            3'b010:  req_trap = |i_req_addr[1:0];
            3'b100:  req_trap = i_req_wen;
            3'b101:  req_trap = i_req_wen | i_req_addr[0];
            default: req_trap = 1'b1;
        endcase

        req_mask = 4'b1111;
        case (i_req_funct3[1:0])
            2'b00:   req_mask = 4'b0001 << i_req_addr[1:0];
            2'b01:   req_mask = 4'b0011 << {i_req_addr[1], 1'b0};
            default: req_mask = 4'b1111;
        endcase
    end

    always_comb begin
        rdata_shifted = i_mem_rdata >> {off_q, 3'b000};
        load_data     = rdata_shifted;
        case (funct3_q)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_req_valid) state_d = req_trap ? S_RESP : S_REQ;
            S_REQ:   if (i_mem_ready) state_d = i_mem_valid ? S_RESP : S_WAIT;
            S_WAIT:  if (i_mem_valid) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response fields are nonzero only during the RESP cycle.
    always_comb begin
        wen_d       = wen_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_mask_d  = mem_mask_q;
        mem_wdata_d = mem_wdata_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        rsp_valid_d = 1'b0;
        rsp_trap_d  = 1'b0;
        rsp_data_d  = 32'd0;
        rsp_rd_d    = 5'd0;

        if (req_fire) begin
            wen_d    = i_req_wen;
            funct3_d = i_req_funct3;
            off_d    = i_req_addr[1:0];
            rd_d     = i_req_rd;
            if (req_trap) begin
                rsp_valid_d = 1'b1;
                rsp_trap_d  = 1'b1;
            end else begin
                mem_addr_d  = {i_req_addr[31:2], 2'b00};
                mem_mask_d  = req_mask;
                mem_wdata_d = i_req_wdata << {i_req_addr[1:0], 3'b000};
                mem_ren_d   = ~i_req_wen;
                mem_wen_d   = i_req_wen;
            end
        end

        if ((state_q == S_REQ) && i_mem_ready) begin
            mem_ren_d = 1'b0;
            mem_wen_d = 1'b0;
        end

        if (mem_done) begin
            rsp_valid_d = 1'b1;
            if (!wen_q) begin
                rsp_data_d = load_data;
                rsp_rd_d   = rd_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop is reset because each one feeds an output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            wen_q       <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            mem_addr_q  <= 32'd0;
            mem_mask_q  <= 4'd0;
            mem_wdata_q <= 32'd0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_trap_q  <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_rd_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_mask_q  <= mem_mask_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_trap_q  <= rsp_trap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_mask  = mem_mask_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_ren   = mem_ren_q;
    assign o_mem_wen   = mem_wen_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_trap  = rsp_trap_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus random ops
// compared against a byte-level reference model of the load/store rules.
module tb_dmem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen, mem_ready, mem_valid;
    logic [3:0]  mem_mask;
    logic        rsp_valid, rsp_trap;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_wen    (req_wen),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_rd     (req_rd),
        .o_mem_addr   (mem_addr),
        .o_mem_ren    (mem_ren),
        .o_mem_wen    (mem_wen),
        .o_mem_wdata  (mem_wdata),
        .o_mem_mask   (mem_mask),
        .i_mem_ready  (mem_ready),
        .i_mem_valid  (mem_valid),
        .i_mem_rdata  (mem_rdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_rsp_rd     (rsp_rd),
        .o_rsp_trap   (rsp_trap)
    );

    // ---------------- reference model ----------------
    function automatic int access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_trap(input logic wen, input logic [2:0] f3, input logic [31:0] addr);
        int a = int'(addr % 4);
        case (f3)
            3'b000:  return 0;
            3'b001:  return (a % 2) != 0;
            3'b010:  return a != 0;
            3'b100:  return wen;
            3'b101:  return wen || ((a % 2) != 0);
            default: return 1;
        endcase
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
        int lane = int'(addr % 4);
        int size = access_size(f3);
        return 4'(((1 << size) - 1) << lane);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int    lane = int'(addr % 4);
        int    size = access_size(f3);
        longint v = 0;
        for (int i = 0; i < size; i++)
            v += longint'(word[8*(lane+i) +: 8]) << (8*i);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1)))
            v -= (longint'(1) << (8*size));
        return v[31:0];
    endfunction

    // ---------------- generic transaction driver ----------------
    task automatic do_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int rdly, input int vdly, input logic [31:0] rdata,
                         input string tag);
        bit          trap  = model_trap(wen, f3, addr);
        logic [3:0]  emask = model_mask(f3, addr);
        logic [31:0] eaddr = addr & 32'hFFFF_FFFC;
        logic [31:0] ewd   = wdata << (8 * (addr % 4));
        logic [31:0] edata = wen ? 32'd0 : model_load(f3, addr, rdata);
        logic [4:0]  erd   = wen ? 5'd0 : rd;
        logic [1:0]  estb;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++; $display("FAIL %s ready_idle: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        if (trap) begin
            n_checks++;
            if ({req_ready, rsp_valid, rsp_trap, rsp_data, rsp_rd, mem_ren, mem_wen} !==
                {1'b0, 1'b1, 1'b1, 32'd0, 5'd0, 1'b0, 1'b0}) begin
                n_fails++;
                $display("FAIL %s trap_rsp: got rdy=%b v=%b trap=%b d=%h rd=%0d ren=%b wen=%b want 0 1 1 0 0 0 0",
                         tag, req_ready, rsp_valid, rsp_trap, rsp_data, rsp_rd, mem_ren, mem_wen);
            end
        end else begin
            for (int k = 0; k <= rdly + vdly; k++) begin
                estb = (k > rdly) ? 2'b00 : {~wen, wen};
                n_checks++;
                if ({req_ready, rsp_valid, mem_ren, mem_wen} !== {2'b00, estb}) begin
                    n_fails++;
                    $display("FAIL %s strobes k=%0d: got rdy=%b v=%b ren=%b wen=%b want 0 0 %b",
                             tag, k, req_ready, rsp_valid, mem_ren, mem_wen, estb);
                end
                if (k <= rdly) begin
                    n_checks++;
                    if ({mem_addr, mem_mask} !== {eaddr, emask}) begin
                        n_fails++;
                        $display("FAIL %s addr_mask k=%0d: got %h/%b want %h/%b",
                                 tag, k, mem_addr, mem_mask, eaddr, emask);
                    end
                    if (wen) begin
                        n_checks++;
                        if (mem_wdata !== ewd) begin
                            n_fails++;
                            $display("FAIL %s wdata k=%0d: got %h want %h", tag, k, mem_wdata, ewd);
                        end
                    end
                end
                mem_ready = (k == rdly);
                mem_valid = (k == rdly + vdly);
                mem_rdata = mem_valid ? rdata : $urandom;
                @(negedge clk);
            end
            mem_ready = 1'b0; mem_valid = 1'b0;
            n_checks++;
            if ({req_ready, rsp_valid, rsp_trap, mem_ren, mem_wen, rsp_data, rsp_rd} !==
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, edata, erd}) begin
                n_fails++;
                $display("FAIL %s rsp: got rdy=%b v=%b trap=%b ren=%b wen=%b d=%h rd=%0d want 0 1 0 0 0 d=%h rd=%0d",
                         tag, req_ready, rsp_valid, rsp_trap, mem_ren, mem_wen, rsp_data, rsp_rd, edata, erd);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, mem_ren, mem_wen} !== 4'b1000) begin
            n_fails++;
            $display("FAIL %s after_rsp: got rdy=%b v=%b ren=%b wen=%b want 1 0 0 0",
                     tag, req_ready, rsp_valid, mem_ren, mem_wen);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({req_ready, mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask,
             rsp_valid, rsp_data, rsp_rd, rsp_trap} !== {1'b1, 109'd0}) begin
            n_fails++;
            $display("FAIL %s reset_outputs: got rdy=%b a=%h ren=%b wen=%b wd=%h m=%b v=%b d=%h rd=%0d t=%b want ready=1 all else 0",
                     tag, req_ready, mem_addr, mem_ren, mem_wen, mem_wdata, mem_mask,
                     rsp_valid, rsp_data, rsp_rd, rsp_trap);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; req_rd = 5'd0; mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");
    endtask

    task automatic test_load_word;
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, "lw_0x100");
    endtask

    task automatic test_byte_loads;
        do_op(1'b0, 3'b000, 32'h203, 32'h0, 5'd9,  2, 1, 32'h80FFFFFF, "lb_0x203");
        do_op(1'b0, 3'b100, 32'h203, 32'h0, 5'd10, 2, 1, 32'h80FFFFFF, "lbu_0x203");
        do_op(1'b0, 3'b001, 32'h002, 32'h0, 5'd11, 0, 2, 32'h7FFF1234, "lh_0x002");
    endtask

    task automatic test_store_half;
        do_op(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 5'd7, 0, 0, 32'h0, "sh_0x302");
        do_op(1'b1, 3'b000, 32'h301, 32'h123456EF, 5'd7, 1, 1, 32'h0, "sb_0x301");
    endtask

    task automatic test_traps;
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd3, 0, 0, 32'h0, "lw_0x101");
        do_op(1'b1, 3'b001, 32'h001, 32'h5555, 5'd3, 0, 0, 32'h0, "sh_0x001");
        do_op(1'b0, 3'b011, 32'h100, 32'h0, 5'd3, 0, 0, 32'h0, "ld_f3_011");
        do_op(1'b1, 3'b100, 32'h100, 32'h0, 5'd3, 0, 0, 32'h0, "store_f3_100");
    endtask

    task automatic test_reset_in_flight;
        // reset while the REQ strobe is up
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500; req_rd = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (mem_ren !== 1'b1) begin
            n_fails++; $display("FAIL rst_req pre_ren: got %b want 1", mem_ren);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_req");
        // reset while waiting for read data, followed by a stale valid
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        mem_valid = 1'b0;
        check_reset_outputs("rst_late_valid");
        do_op(1'b0, 3'b101, 32'h402, 32'h0, 5'd12, 0, 1, {16'h8001, 16'($urandom)}, "lhu_0x402");
    endtask

    task automatic test_back_to_back;
        logic [31:0] word = 32'h11223344;
        bit          exp_ready[6] = '{1, 0, 0, 1, 0, 0};
        bit          exp_rsp[6]   = '{0, 0, 1, 0, 0, 1};
        logic [31:0] ed_a = model_load(3'b010, 32'h10, word);
        logic [31:0] ed_b = model_load(3'b100, 32'h11, word);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_rd = 5'd3;
        mem_ready = 1'b1; mem_valid = 1'b1; mem_rdata = word;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if ({req_ready, rsp_valid} !== {exp_ready[c], exp_rsp[c]}) begin
                n_fails++;
                $display("FAIL b2b cycle%0d: got rdy=%b v=%b want %b %b",
                         c, req_ready, rsp_valid, exp_ready[c], exp_rsp[c]);
            end
            if (c == 2 || c == 5) begin
                n_checks++;
                if ({rsp_data, rsp_rd} !== ((c == 2) ? {ed_a, 5'd3} : {ed_b, 5'd7})) begin
                    n_fails++;
                    $display("FAIL b2b rsp%0d: got d=%h rd=%0d want %h", c, rsp_data, rsp_rd,
                             (c == 2) ? ed_a : ed_b);
                end
            end
            if (c == 1) begin
                req_funct3 = 3'b100; req_addr = 32'h11; req_rd = 5'd7;
            end
            if (c == 4) req_valid = 1'b0;
            @(negedge clk);
        end
        mem_ready = 1'b0; mem_valid = 1'b0;
        n_checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_fails++; $display("FAIL b2b idle: got rdy=%b v=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            logic        wen  = 1'($urandom);
            logic [2:0]  f3   = 3'($urandom);
            logic [31:0] addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            do_op(wen, f3, addr, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), $urandom, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_byte_loads();
        test_store_half();
        test_traps();
        test_reset_in_flight();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
